// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: default widths,
// control-bundle bit positions, the payload layout and the skid-stage states.
package pipe_pkg;

    localparam int unsigned PIPE_CTRL_W = 4;
    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_ADDR_W = 5;

    // Bit positions inside the control bundle
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_MEMREAD  = 2;
    localparam int unsigned CTRL_MEMWRITE = 3;

    // Skid stage occupancy: nothing, main only, main plus skid
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_ONE   = 2'd1,
        SLOT_FULL  = 2'd2
    } slot_state_e;

    // Payload layout at default widths, MSB first: ctrl, data0, data1, rd
    typedef struct packed {
        logic [PIPE_CTRL_W-1:0] ctrl;
        logic [PIPE_DATA_W-1:0] data0;
        logic [PIPE_DATA_W-1:0] data1;
        logic [PIPE_ADDR_W-1:0] rd;
    } pipe_payload_t;

    // Width of the flattened payload bus for arbitrary field widths
    function automatic int unsigned payload_width(input int unsigned ctrl_w,
                                                  input int unsigned data_w,
                                                  input int unsigned addr_w);
        return ctrl_w + 2 * data_w + addr_w;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One two-entry skid stage with valid/ready handshake and synchronous flush.
// Ports: clk_i/rst_n_i clock and async active-low reset; flush_i empties the
// stage; valid_i/ready_o/data_i upstream side; valid_o/ready_i/data_o
// downstream side. ready_o and valid_o are decoded purely from flops.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int unsigned W = 73
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         flush_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    slot_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         ready_q, ready_d;
    logic         in_xfer;
    logic         out_xfer;

    assign in_xfer  = valid_i & ready_q;
    assign out_xfer = (state_q != SLOT_EMPTY) & ready_i;

    // Next-state and slot data selection
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (in_xfer) begin
                    main_d  = data_i;
                    state_d = SLOT_ONE;
                end
            end
            SLOT_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = data_i;
                end else if (in_xfer) begin
                    skid_d  = data_i;
                    state_d = SLOT_FULL;
                end else if (out_xfer) begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                // ready_q is low here, so only the drain path applies
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = SLOT_ONE;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
        // Flush overrides any transfer; a downstream beat taken this cycle is
        // already consumed, so dropping it from the slot is correct.
        if (flush_i) begin
            state_d = SLOT_EMPTY;
        end
        ready_d = (state_d != SLOT_FULL);
    end

    // State and data registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= SLOT_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = (state_q != SLOT_EMPTY);
    assign data_o  = main_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: DEPTH chained skid stages carrying a control
// bundle, two data words and a destination register address.
// Ports: clk_i/rst_n_i clock and async active-low reset; flush_i turns all
// in-flight entries into bubbles; valid_i/ready_o and ctrl_i/data0_i/data1_i/
// rd_i upstream; valid_o/ready_i and ctrl_o/data0_o/data1_o/rd_o downstream.
// ctrl_o and rd_o read as zero whenever valid_o is low.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned ADDR_W = PIPE_ADDR_W,
    parameter int unsigned DEPTH  = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data0_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [ADDR_W-1:0] rd_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data0_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [ADDR_W-1:0] rd_o
);

    localparam int unsigned PAYLOAD_W = payload_width(CTRL_W, DATA_W, ADDR_W);

    // Index s is the input of stage s; index DEPTH is the block output
    logic [DEPTH:0]                valid_chain;
    logic [DEPTH:0]                ready_chain;
    logic [DEPTH:0][PAYLOAD_W-1:0] data_chain;

    logic [CTRL_W-1:0] ctrl_raw;
    logic [ADDR_W-1:0] rd_raw;

    assign valid_chain[0]     = valid_i;
    assign data_chain[0]      = {ctrl_i, data0_i, data1_i, rd_i};
    assign ready_chain[DEPTH] = ready_i;
    assign ready_o            = ready_chain[0];

    // Stage chain
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        pipe_skid_slot #(
            .W(PAYLOAD_W)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .flush_i (flush_i),
            .valid_i (valid_chain[s]),
            .ready_o (ready_chain[s]),
            .data_i  (data_chain[s]),
            .valid_o (valid_chain[s+1]),
            .ready_i (ready_chain[s+1]),
            .data_o  (data_chain[s+1])
        );
    end

    // Unpack and keep bubbles harmless: no RegWrite/MemWrite or rd from a bubble
    assign {ctrl_raw, data0_o, data1_o, rd_raw} = data_chain[DEPTH];
    assign valid_o = valid_chain[DEPTH];
    assign ctrl_o  = valid_o ? ctrl_raw : '0;
    assign rd_o    = valid_o ? rd_raw   : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: three instances with DEPTH 1, 2 and 3
// share the payload inputs but have private valid/ready/flush.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned NI = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  ctrl_i;
    logic [31:0] data0_i, data1_i;
    logic [4:0]  rd_i;

    logic        valid_i [NI];
    logic        ready_i [NI];
    logic        flush_i [NI];
    logic        ready_o [NI];
    logic        valid_o [NI];
    logic [3:0]  ctrl_o  [NI];
    logic [31:0] data0_o [NI];
    logic [31:0] data1_o [NI];
    logic [4:0]  rd_o    [NI];

    pipe_payload_t exp_q [NI][$];
    int unsigned   n_out [NI];
    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pipe_stage_reg #(
            .DEPTH(g + 1)
        ) u_dut (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .flush_i (flush_i[g]),
            .valid_i (valid_i[g]),
            .ready_o (ready_o[g]),
            .ctrl_i  (ctrl_i),
            .data0_i (data0_i),
            .data1_i (data1_i),
            .rd_i    (rd_i),
            .valid_o (valid_o[g]),
            .ready_i (ready_i[g]),
            .ctrl_o  (ctrl_o[g]),
            .data0_o (data0_o[g]),
            .data1_o (data1_o[g]),
            .rd_o    (rd_o[g])
        );

        // Monitor: sampled mid-cycle, reflects the transfers of the next edge
        always @(negedge clk) begin
            pipe_payload_t e;
            if (!rst_n) begin
                exp_q[g].delete();
            end else begin
                if (valid_o[g] && ready_i[g]) begin
                    n_out[g]++;
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("unexpected_out%0d", g), 64'(rd_o[g]), 64'hdead);
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("ctrl%0d", g),  64'(ctrl_o[g]),  64'(e.ctrl));
                        check($sformatf("data0_%0d", g), 64'(data0_o[g]), 64'(e.data0));
                        check($sformatf("data1_%0d", g), 64'(data1_o[g]), 64'(e.data1));
                        check($sformatf("rd%0d", g),    64'(rd_o[g]),    64'(e.rd));
                    end
                end
                if (!valid_o[g]) begin
                    check($sformatf("bubble_ctrl%0d", g), 64'(ctrl_o[g]), 64'h0);
                    check($sformatf("bubble_rd%0d", g),   64'(rd_o[g]),   64'h0);
                end
                if (flush_i[g]) begin
                    exp_q[g].delete();
                end else if (valid_i[g] && ready_o[g]) begin
                    exp_q[g].push_back({ctrl_i, data0_i, data1_i, rd_i});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int unsigned sent;
        int unsigned cyc;
        logic        r;

        for (int i = 0; i < int'(NI); i++) begin
            valid_i[i] = 1'b0;
            ready_i[i] = 1'b1;
            flush_i[i] = 1'b0;
            n_out[i]   = 0;
        end
        ctrl_i = '0; data0_i = '0; data1_i = '0; rd_i = '0;

        // Power-on reset
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < int'(NI); i++) begin
            check($sformatf("rst_ready%0d", i), 64'(ready_o[i]), 64'h1);
            check($sformatf("rst_valid%0d", i), 64'(valid_o[i]), 64'h0);
        end

        // Streaming, DEPTH=2: latency 2, one per cycle, ready never drops
        base = n_out[1];
        for (int i = 1; i <= 8; i++) begin
            valid_i[1] = 1'b1;
            ctrl_i  = 4'(i);
            data0_i = 32'(16 * i);
            data1_i = ~32'(i);
            rd_i    = 5'(i);
            tick();
            check("stream_ready", 64'(ready_o[1]), 64'h1);
            if (i == 1) check("stream_lat_early", 64'(valid_o[1]), 64'h0);
            if (i == 2) begin
                check("stream_lat_valid", 64'(valid_o[1]), 64'h1);
                check("stream_lat_rd", 64'(rd_o[1]), 64'h1);
                check("stream_lat_data0", 64'(data0_o[1]), 64'h10);
            end
        end
        valid_i[1] = 1'b0;
        repeat (4) tick();
        check("stream_count", 64'(n_out[1] - base), 64'd8);

        // Backpressure, DEPTH=1: two accepted, third held
        base = n_out[0];
        ready_i[0] = 1'b0;
        valid_i[0] = 1'b1; ctrl_i = 4'h1; data0_i = 32'hA0; data1_i = 32'hA1; rd_i = 5'd10;
        tick();
        check("bp_ready_c1", 64'(ready_o[0]), 64'h1);
        ctrl_i = 4'h2; data0_i = 32'hB0; data1_i = 32'hB1; rd_i = 5'd11;
        tick();
        check("bp_ready_c2", 64'(ready_o[0]), 64'h0);
        ctrl_i = 4'h4; data0_i = 32'hC0; data1_i = 32'hC1; rd_i = 5'd12;
        tick();
        check("bp_ready_c3", 64'(ready_o[0]), 64'h0);
        check("bp_head_rd", 64'(rd_o[0]), 64'd10);
        ready_i[0] = 1'b1;
        repeat (2) tick();
        valid_i[0] = 1'b0;
        repeat (3) tick();
        check("bp_count", 64'(n_out[0] - base), 64'd3);

        // Bubble: control present without valid must not reach the output
        ctrl_i = 4'b1001; rd_i = 5'd31;
        repeat (3) tick();
        check("bubble_valid", 64'(valid_o[0]), 64'h0);
        check("bubble_regwrite", 64'(ctrl_o[0][CTRL_REGWRITE]), 64'h0);
        check("bubble_memwrite", 64'(ctrl_o[0][CTRL_MEMWRITE]), 64'h0);

        // Flush, DEPTH=3 with downstream stages full and a valid beat offered
        base = n_out[2];
        ready_i[2] = 1'b0;
        sent = 0; cyc = 0;
        while (sent < 4 && cyc < 50) begin
            valid_i[2] = 1'b1;
            ctrl_i = 4'hF; data0_i = 32'(100 + sent); data1_i = 32'(200 + sent); rd_i = 5'(20 + sent);
            if (ready_o[2]) sent++;
            tick();
            cyc++;
        end
        check("flush_fill", 64'(sent), 64'd4);
        valid_i[2] = 1'b0;
        repeat (8) tick();
        check("flush_pre_valid", 64'(valid_o[2]), 64'h1);
        flush_i[2] = 1'b1; valid_i[2] = 1'b1;
        ctrl_i = 4'hF; data0_i = 32'h555; rd_i = 5'd25;
        tick();
        flush_i[2] = 1'b0; valid_i[2] = 1'b0;
        check("flush_valid", 64'(valid_o[2]), 64'h0);
        check("flush_ctrl", 64'(ctrl_o[2]), 64'h0);
        check("flush_ready", 64'(ready_o[2]), 64'h1);
        ready_i[2] = 1'b1;
        valid_i[2] = 1'b1; ctrl_i = 4'h3; data0_i = 32'h1234; data1_i = 32'h5678; rd_i = 5'd7;
        tick();
        valid_i[2] = 1'b0;
        repeat (6) tick();
        check("flush_after_count", 64'(n_out[2] - base), 64'd1);

        // Random valid/ready, DEPTH=3, 1000 beats
        base = n_out[2];
        sent = 0; cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            valid_i[2] = 1'($urandom_range(0, 1));
            ready_i[2] = 1'($urandom_range(0, 1));
            ctrl_i = 4'($urandom); data0_i = $urandom; data1_i = $urandom; rd_i = 5'($urandom);
            if (cyc % 100 == 0) begin
                r = ready_o[2];
                ready_i[2] = ~ready_i[2];
                #1;
                check("ready_no_comb", 64'(ready_o[2]), 64'(r));
                ready_i[2] = ~ready_i[2];
            end
            if (valid_i[2] && ready_o[2]) sent++;
            tick();
            cyc++;
        end
        check("rand_sent", 64'(sent), 64'd1000);
        valid_i[2] = 1'b0;
        ready_i[2] = 1'b1;
        repeat (20) tick();
        check("rand_count", 64'(n_out[2] - base), 64'd1000);

        // Asynchronous reset with two live entries, DEPTH=1
        ready_i[0] = 1'b0;
        valid_i[0] = 1'b1; ctrl_i = 4'b1001; data0_i = 32'hEE; data1_i = 32'hEF; rd_i = 5'd9;
        repeat (2) tick();
        valid_i[0] = 1'b0;
        check("rst_pre_valid", 64'(valid_o[0]), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(valid_o[0]), 64'h0);
        check("arst_ctrl", 64'(ctrl_o[0]), 64'h0);
        check("arst_rd", 64'(rd_o[0]), 64'h0);
        check("arst_data0", 64'(data0_o[0]), 64'h0);
        tick();
        rst_n = 1'b1;
        ready_i[0] = 1'b1;
        tick();
        check("arst_ready_after", 64'(ready_o[0]), 64'h1);
        repeat (3) tick();

        for (int i = 0; i < int'(NI); i++) begin
            check($sformatf("queue_empty%0d", i), 64'(exp_q[i].size()), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
